// File: rtl/alt_est_pkg.sv
// Shared widths, FSM encoding and operand bundle for the s1 calculator scheduler.
package alt_est_pkg;
    localparam int NV_W  = 21;
    localparam int NU_W  = 25;
    localparam int NO_W  = 21;
    localparam int S1_W  = 32;
    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    typedef struct packed {
        logic [NV_W-1:0] nv;
        logic [NU_W-1:0] nu;
        logic [NO_W-1:0] no;
    } ops_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/alt_rr_arb.sv
// Round-robin arbiter: first set request after ptr (wrapping), one-hot grant plus index.
module alt_rr_arb #(
    parameter int NCH = 3,
    parameter int IDW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] id,
    output logic           any
);
    int idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!any && req[idx]) begin
                any = 1'b1;
                id  = IDW'(idx);
            end
        end
        if (any) gnt[id] = 1'b1;
    end
endmodule

// File: rtl/alt_est_sched.sv
// Time-shares one s1 calculator among NCH requesters: arbitrate, launch, wait/timeout, respond.
module alt_est_sched
    import alt_est_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64,
    parameter int FLUSH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      i_req,
    input  logic [NV_W*NCH-1:0] i_nv,
    input  logic [NU_W*NCH-1:0] i_nu,
    input  logic [NO_W*NCH-1:0] i_no,
    output logic [NCH-1:0]      o_gnt,
    output logic                o_rsp_vld,
    output logic [IDW-1:0]      o_rsp_id,
    output logic [S1_W-1:0]     o_rsp_s1,
    output logic                o_rsp_err,
    output logic                o_rsp_tmo,
    output logic                o_calc_rst,
    output logic                o_calc_start,
    output logic [NV_W-1:0]     o_calc_nv,
    output logic [NU_W-1:0]     o_calc_nu,
    output logic [NO_W-1:0]     o_calc_no,
    input  logic [S1_W-1:0]     i_calc_s1,
    input  logic                i_calc_vld,
    input  logic                i_calc_err,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_done_cnt,
    output logic [CNT_W-1:0]    o_tmo_cnt
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int FW = $clog2(FLUSH + 1);

    logic [2:0]     state, nxt;
    logic [IDW-1:0] rr_ptr, cur_id, arb_id;
    logic [NCH-1:0] arb_gnt;
    logic           arb_any;
    logic [TW-1:0]  wait_cnt;
    logic [FW-1:0]  flush_cnt;
    logic           boot;
    ops_t           ops;

    wire wait_last = (wait_cnt == TW'(TIMEOUT - 1));
    wire flush_end = (flush_cnt <= FW'(1));

    alt_rr_arb #(.NCH(NCH), .IDW(IDW)) u_arb (
        .req (i_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) nxt = ST_LOAD;
            ST_LOAD:  nxt = ST_START;
            ST_START: nxt = ST_WAIT;
            ST_WAIT:  if (i_calc_vld) nxt = ST_RESP;
                      else if (wait_last) nxt = ST_FLUSH;
            ST_FLUSH: if (flush_end) nxt = boot ? ST_IDLE : ST_RESP;
            ST_RESP:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FLUSH;
            flush_cnt  <= FW'(FLUSH);
            boot       <= 1'b1;
            rr_ptr     <= IDW'(NCH - 1);
            cur_id     <= '0;
            ops        <= '0;
            wait_cnt   <= '0;
            o_rsp_id   <= '0;
            o_rsp_s1   <= '0;
            o_rsp_err  <= 1'b0;
            o_rsp_tmo  <= 1'b0;
            o_done_cnt <= '0;
            o_tmo_cnt  <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE:  if (arb_any) cur_id <= arb_id;
                ST_LOAD: begin
                    ops.nv <= i_nv[int'(cur_id)*NV_W +: NV_W];
                    ops.nu <= i_nu[int'(cur_id)*NU_W +: NU_W];
                    ops.no <= i_no[int'(cur_id)*NO_W +: NO_W];
                    rr_ptr <= cur_id;
                end
                ST_START: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A result arriving on the last allowed cycle still counts as success.
                    if (i_calc_vld) begin
                        o_rsp_id  <= cur_id;
                        o_rsp_s1  <= i_calc_s1;
                        o_rsp_err <= i_calc_err;
                        o_rsp_tmo <= 1'b0;
                    end else if (wait_last) begin
                        flush_cnt <= FW'(FLUSH);
                    end
                end
                ST_FLUSH: begin
                    if (!flush_end) flush_cnt <= flush_cnt - 1'b1;
                    else begin
                        boot <= 1'b0;
                        if (!boot) begin
                            o_rsp_id  <= cur_id;
                            o_rsp_s1  <= '0;
                            o_rsp_err <= 1'b1;
                            o_rsp_tmo <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    o_done_cnt <= sat_inc(o_done_cnt);
                    if (o_rsp_tmo) o_tmo_cnt <= sat_inc(o_tmo_cnt);
                end
                default: ;
            endcase
        end
    end

    assign o_gnt        = (state == ST_LOAD) ? (NCH'(1) << cur_id) : '0;
    assign o_calc_start = (state == ST_START);
    assign o_calc_rst   = (state == ST_FLUSH);
    assign o_rsp_vld    = (state == ST_RESP);
    // The post-reset calculator flush is housekeeping, not a job.
    assign o_busy       = (state != ST_IDLE) && !boot;
    assign o_calc_nv    = ops.nv;
    assign o_calc_nu    = ops.nu;
    assign o_calc_no    = ops.no;
endmodule

// File: tb/tb_alt_est_sched.sv
// Directed scoreboard bench for alt_est_sched with a behavioural calculator and requester model.
module tb_alt_est_sched;
    localparam int NCH = 3, IDW = 2, TIMEOUT = 64, FLUSH = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] s1;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic            clk, rst;
    logic [NCH-1:0]  i_req;
    logic [21*NCH-1:0] i_nv, i_no;
    logic [25*NCH-1:0] i_nu;
    logic [NCH-1:0]  o_gnt;
    logic            o_rsp_vld, o_rsp_err, o_rsp_tmo, o_calc_rst, o_calc_start, o_busy;
    logic [IDW-1:0]  o_rsp_id;
    logic [31:0]     o_rsp_s1, i_calc_s1;
    logic [20:0]     o_calc_nv, o_calc_no;
    logic [24:0]     o_calc_nu;
    logic            i_calc_vld, i_calc_err;
    logic [15:0]     o_done_cnt, o_tmo_cnt;

    alt_est_sched #(.NCH(NCH), .IDW(IDW), .TIMEOUT(TIMEOUT), .FLUSH(FLUSH)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_nv(i_nv), .i_nu(i_nu), .i_no(i_no),
        .o_gnt(o_gnt), .o_rsp_vld(o_rsp_vld), .o_rsp_id(o_rsp_id), .o_rsp_s1(o_rsp_s1),
        .o_rsp_err(o_rsp_err), .o_rsp_tmo(o_rsp_tmo), .o_calc_rst(o_calc_rst),
        .o_calc_start(o_calc_start), .o_calc_nv(o_calc_nv), .o_calc_nu(o_calc_nu),
        .o_calc_no(o_calc_no), .i_calc_s1(i_calc_s1), .i_calc_vld(i_calc_vld),
        .i_calc_err(i_calc_err), .o_busy(o_busy), .o_done_cnt(o_done_cnt), .o_tmo_cnt(o_tmo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0, n_err = 0;
    rsp_t exp_q[$];
    int   gnt_q[$];
    int   reraise[NCH];
    int   n_start = 0, rst_cyc = 0;
    logic [20:0] nv_a[NCH], no_a[NCH];
    logic [24:0] nu_a[NCH];

    // calculator model controls
    int          m_lat = 8;
    bit          m_never = 0, m_fixed = 0, m_ferr = 0;
    logic [31:0] m_s1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [20:0] nv, input logic [24:0] nu, input logic [20:0] no);
        nv_a[k] = nv; nu_a[k] = nu; no_a[k] = no;
        i_nv[21*k +: 21] = nv;
        i_nu[25*k +: 25] = nu;
        i_no[21*k +: 21] = no;
    endtask

    // calculator behaviour: error when the signal count exceeds the decoy count
    function automatic rsp_t model_rsp(input int k);
        rsp_t r;
        r.id  = 2'(k);
        r.err = (no_a[k] > nu_a[k]);
        r.s1  = r.err ? 32'd0 : 32'(nv_a[k]) + 32'(nu_a[k]) - 32'(no_a[k]);
        r.tmo = 1'b0;
        return r;
    endfunction

    task automatic drain(input string tag);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // calculator model
    initial begin
        int cnt; bit armed; logic [31:0] ps1; logic perr;
        cnt = 0; armed = 0; ps1 = '0; perr = 0;
        i_calc_vld = 0; i_calc_s1 = '0; i_calc_err = 0;
        forever begin
            @(negedge clk);
            i_calc_vld = 1'b0;
            if (!rst) armed = 0;
            else begin
                if (armed) begin
                    if (cnt <= 1) begin
                        i_calc_vld = 1'b1; i_calc_s1 = ps1; i_calc_err = perr; armed = 0;
                    end else cnt--;
                end
                if (o_calc_start) begin
                    armed = !m_never;
                    cnt   = m_lat;
                    perr  = m_fixed ? m_ferr : (o_calc_no > o_calc_nu);
                    ps1   = m_fixed ? m_s1 : (perr ? 32'd0 : 32'(o_calc_nv) + 32'(o_calc_nu) - 32'(o_calc_no));
                end
            end
        end
    end

    // requester model and output monitor
    initial begin
        bit prev_gnt; rsp_t r; int e;
        prev_gnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin prev_gnt = 0; continue; end
            if (o_calc_rst) rst_cyc++;
            if (prev_gnt) chk("start_after_gnt", 64'(o_calc_start), 64'd1);
            if (o_calc_start) n_start++;
            if (o_gnt != '0) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(o_gnt), 64'd0);
                else begin
                    e = gnt_q.pop_front();
                    chk("gnt_order", 64'(o_gnt), 64'd1 << e);
                end
                for (int k = 0; k < NCH; k++)
                    if (o_gnt[k]) begin
                        if (reraise[k] > 0) reraise[k]--;
                        else i_req[k] = 1'b0;
                    end
            end
            prev_gnt = (o_gnt != '0);
            if (o_rsp_vld) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    r = exp_q.pop_front();
                    chk("rsp", 64'({o_rsp_id, o_rsp_s1, o_rsp_err, o_rsp_tmo}), 64'(r));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, rc0, c;
        rst = 1'b0; i_req = '0; i_nv = '0; i_nu = '0; i_no = '0;
        for (int k = 0; k < NCH; k++) begin reraise[k] = 0; set_ops(k, 21'd0, 25'd0, 21'd0); end
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_calc_rst", 64'(o_calc_rst), 64'd1);
        chk("rst_outs", 64'({o_gnt, o_rsp_vld, o_calc_start, o_busy, o_rsp_err, o_rsp_tmo}), 64'd0);
        chk("rst_cnts", 64'({o_done_cnt, o_tmo_cnt, o_rsp_s1}), 64'd0);
        rst = 1'b1;
        @(negedge clk); chk("boot_flush1", 64'(o_calc_rst), 64'd1);
        @(negedge clk); chk("boot_flush_end", 64'(o_calc_rst), 64'd0);

        // single request, fixed calculator result
        set_ops(0, 21'd1000, 25'd20000, 21'd500);
        m_fixed = 1; m_s1 = 32'd1234; m_ferr = 0; m_lat = 8;
        exp_q.push_back('{2'd0, 32'd1234, 1'b0, 1'b0});
        gnt_q.push_back(0);
        i_req = 3'b001;
        @(negedge clk); chk("t1_gnt", 64'(o_gnt), 64'b001); chk("t1_busy", 64'(o_busy), 64'd1);
        @(negedge clk); chk("t1_start", 64'(o_calc_start), 64'd1);
        chk("t1_ops", 64'({o_calc_nv, o_calc_nu, o_calc_no}), 64'({21'd1000, 25'd20000, 21'd500}));
        drain("t1_drain");
        chk("t1_done", 64'(o_done_cnt), 64'd1);
        chk("t1_hold", 64'({o_rsp_vld, o_rsp_s1}), 64'({1'b0, 32'd1234}));

        // all three from reset, requester 0 re-raises once; requester 1 hits calculator error
        do_reset();
        chk("t2_rr_done", 64'(o_done_cnt), 64'd0);
        set_ops(0, 21'd10, 25'd5000, 21'd300);
        set_ops(1, 21'd7, 25'd100, 21'd900);
        set_ops(2, 21'd2000, 25'h100_0000, 21'd12345);
        m_fixed = 0; m_lat = 3;
        reraise[0] = 1;
        foreach (gnt_q[i]) ;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(0);
        exp_q.push_back(model_rsp(0)); exp_q.push_back(model_rsp(1));
        exp_q.push_back(model_rsp(2)); exp_q.push_back(model_rsp(0));
        st0 = n_start;
        i_req = 3'b111;
        drain("t2_drain");
        chk("t2_done", 64'(o_done_cnt), 64'd4);
        chk("t2_starts", 64'(n_start - st0), 64'd4);
        chk("t2_tmo", 64'(o_tmo_cnt), 64'd0);

        // timeout: calculator never answers
        m_never = 1; rc0 = rst_cyc;
        gnt_q.push_back(2);
        exp_q.push_back('{2'd2, 32'd0, 1'b1, 1'b1});
        i_req = 3'b100;
        drain("t3_drain");
        chk("t3_calc_rst_cycles", 64'(rst_cyc - rc0), 64'd2);
        chk("t3_tmo_cnt", 64'(o_tmo_cnt), 64'd1);
        chk("t3_done", 64'(o_done_cnt), 64'd5);

        // result on the exact timeout cycle wins
        m_never = 0; m_fixed = 1; m_s1 = 32'hDEAD_BEEF; m_ferr = 0; m_lat = TIMEOUT;
        rc0 = rst_cyc;
        gnt_q.push_back(1);
        exp_q.push_back('{2'd1, 32'hDEAD_BEEF, 1'b0, 1'b0});
        i_req = 3'b010;
        drain("t4_drain");
        chk("t4_no_calc_rst", 64'(rst_cyc - rc0), 64'd0);
        chk("t4_tmo_cnt", 64'(o_tmo_cnt), 64'd1);

        // stray calculator strobe while idle is ignored
        #1 i_calc_vld = 1'b1; i_calc_s1 = 32'h5555;
        repeat (3) @(negedge clk);
        chk("stray_vld_done", 64'(o_done_cnt), 64'd6);

        // reset while waiting; pending requests re-arbitrated from id 0
        m_never = 1;
        gnt_q.push_back(0);
        i_req = 3'b001;
        c = 0;
        while (!o_calc_start && c < 20) begin @(negedge clk); c++; end
        chk("t5_started", 64'(o_calc_start), 64'd1);
        repeat (5) @(negedge clk);
        i_req = 3'b011;
        rst = 1'b0;
        #1;
        chk("t5_rst_calc_rst", 64'(o_calc_rst), 64'd1);
        chk("t5_rst_outs", 64'({o_gnt, o_rsp_vld, o_calc_start, o_busy, o_calc_nv}), 64'd0);
        chk("t5_rst_cnts", 64'({o_done_cnt, o_tmo_cnt, o_rsp_s1}), 64'd0);
        m_never = 0; m_s1 = 32'd77; m_lat = 5;
        gnt_q.push_back(0); gnt_q.push_back(1);
        exp_q.push_back('{2'd0, 32'd77, 1'b0, 1'b0});
        exp_q.push_back('{2'd1, 32'd77, 1'b0, 1'b0});
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); chk("t5_flush1", 64'(o_calc_rst), 64'd1);
        @(negedge clk); chk("t5_flush_end", 64'(o_calc_rst), 64'd0);
        drain("t5_drain");
        chk("t5_done", 64'(o_done_cnt), 64'd2);
        chk("t5_gnt_q", 64'(gnt_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
